// File: rtl/ssl_scan_pkg.sv
// Shared types and helpers for the two-digit multiplexed 7-segment scanner.
package ssl_scan_pkg;

    typedef enum logic [1:0] {S_BLANK0, S_SHOW0, S_BLANK1, S_SHOW1} scan_state_t;

    localparam logic [6:0] SEG_OFF = '0;

    // Slot-counter width: enough bits to reach max(scan, blank) - 1, never zero.
    function automatic int cnt_width(input int scan, input int blank);
        int m;
        int w;
        m = (scan > blank) ? scan : blank;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ssl_scan_2digit_slot_timer.sv
// Terminal counter for one display slot; the length is reloaded on every slot boundary.
module slot_timer #(
    parameter int            CW      = 1,
    parameter int            LW      = CW + 1,
    parameter logic [LW-1:0] RST_LEN = LW'(1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_len,
    input  logic [LW-1:0] len,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [LW-1:0] len_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            len_q <= RST_LEN;
        end else if (load_len) begin
            cnt_q <= '0;
            len_q <= len;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign last = ({1'b0, cnt_q} == (len_q - LW'(1)));

endmodule

// File: rtl/ssl_scan_2digit.sv
// Two-digit common-bus 7-segment scanner: blank, show ones, blank, show tens, with
// patterns latched at each blank exit and all pin outputs driven straight from flops.
module ssl_scan_2digit
    import ssl_scan_pkg::*;
#(
    parameter int SCAN_CYCLES    = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] ssl1,
    input  logic [6:0] ssl0,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       frame_done
);

    if (SCAN_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("ssl_scan_2digit: SCAN_CYCLES and BLANK_CYCLES must both be >= 1");
    end

    localparam int            CW        = cnt_width(SCAN_CYCLES, BLANK_CYCLES);
    localparam int            LW        = CW + 1;
    localparam logic [LW-1:0] SCAN_LEN  = LW'(SCAN_CYCLES);
    localparam logic [LW-1:0] BLANK_LEN = LW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_POL   = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0]    DIG_POL   = {2{DIG_ACTIVE_LOW}};

    scan_state_t   state_q;
    logic [6:0]    pat_q;
    logic [6:0]    seg_q;
    logic [1:0]    dig_q;
    logic          frame_q;
    logic          slot_last;
    logic [LW-1:0] len_d;

    // Length of the slot that starts when the current one ends.
    assign len_d = (state_q == S_BLANK0 || state_q == S_BLANK1) ? SCAN_LEN : BLANK_LEN;

    slot_timer #(
        .CW      (CW),
        .LW      (LW),
        .RST_LEN (BLANK_LEN)
    ) u_slot_timer (
        .clock    (clock),
        .reset    (reset),
        .load_len (slot_last),
        .len      (len_d),
        .last     (slot_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_BLANK0;
            pat_q   <= SEG_OFF;
            seg_q   <= SEG_OFF ^ SEG_POL;
            dig_q   <= 2'b00 ^ DIG_POL;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            // Mid-slot the bus simply re-drives the latched pattern (or off while blanking).
            seg_q   <= (state_q == S_SHOW0 || state_q == S_SHOW1) ? (pat_q ^ SEG_POL)
                                                                    : (SEG_OFF ^ SEG_POL);
            if (slot_last) begin
                case (state_q)
                    S_BLANK0: begin
                        state_q <= S_SHOW0;
                        pat_q   <= ssl0;
                        seg_q   <= ssl0 ^ SEG_POL;
                        dig_q   <= 2'b01 ^ DIG_POL;
                    end
                    S_SHOW0: begin
                        state_q <= S_BLANK1;
                        seg_q   <= SEG_OFF ^ SEG_POL;
                        dig_q   <= 2'b00 ^ DIG_POL;
                    end
                    S_BLANK1: begin
                        state_q <= S_SHOW1;
                        pat_q   <= ssl1;
                        seg_q   <= ssl1 ^ SEG_POL;
                        dig_q   <= 2'b10 ^ DIG_POL;
                    end
                    S_SHOW1: begin
                        state_q <= S_BLANK0;
                        seg_q   <= SEG_OFF ^ SEG_POL;
                        dig_q   <= 2'b00 ^ DIG_POL;
                        frame_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_ssl_scan_2digit.sv
// Scoreboard bench: two scanner configurations share stimulus; a frame-position model
// predicts every cycle's pins and a monitor compares them.
module tb_ssl_scan_2digit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] ssl1  = '0;
    logic [6:0] ssl0  = '0;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dig_a, dig_b;
    logic       fd_a, fd_b;

    always #5 clock = ~clock;

    ssl_scan_2digit #(
        .SCAN_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clock(clock), .reset(reset), .ssl1(ssl1), .ssl0(ssl0),
        .seg(seg_a), .dig(dig_a), .frame_done(fd_a)
    );

    ssl_scan_2digit #(
        .SCAN_CYCLES(1), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .ssl1(ssl1), .ssl0(ssl0),
        .seg(seg_b), .dig(dig_b), .frame_done(fd_b)
    );

    typedef struct {
        int         k;
        logic [6:0] seg_a;
        logic [1:0] dig_a;
        logic       fd_a;
        logic [6:0] seg_b;
        logic [1:0] dig_b;
        logic       fd_b;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pushed = 0;
    int         popped = 0;
    logic [6:0] h0 [0:4095];
    logic [6:0] h1 [0:4095];
    bit         hrst [0:4095];
    int         k = 0;
    int         t = 0;
    bit         live = 1'b0;

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    // Pins for cycle k, t cycles after restart: derived from position within the frame
    // and the input value that was present on the edge ending the preceding blank slot.
    function automatic void model(input int tt, input int kk, input int s, input int b,
                                  input bit sal, input bit dal, output logic [6:0] o_seg,
                                  output logic [1:0] o_dig, output logic o_fd);
        int         p;
        int         pos;
        logic [6:0] pat;
        logic [1:0] d;
        p   = 2 * (s + b);
        pos = tt % p;
        pat = 7'h00;
        d   = 2'b00;
        if (pos >= b && pos < b + s) begin
            pat = h0[kk - pos + b - 1];
            d   = 2'b01;
        end else if (pos >= 2 * b + s) begin
            pat = h1[kk - pos + 2 * b + s - 1];
            d   = 2'b10;
        end
        o_seg = pat ^ {7{sal}};
        o_dig = d ^ {2{dal}};
        o_fd  = (pos == 0) && (tt >= p);
    endfunction

    task automatic step(input bit rst, input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        @(negedge clock);
        if (k > 0 && hrst[k-1]) begin
            live = 1'b1;
            t    = 0;
        end else begin
            t++;
        end
        if (live) begin
            e.k = k;
            model(t, k, 4, 2, 1'b0, 1'b0, e.seg_a, e.dig_a, e.fd_a);
            model(t, k, 1, 1, 1'b1, 1'b1, e.seg_b, e.dig_b, e.fd_b);
            sb_q.push_back(e);
            pushed++;
        end
        reset   = rst;
        ssl1    = s1;
        ssl0    = s0;
        h0[k]   = s0;
        h1[k]   = s1;
        hrst[k] = rst;
        k++;
    endtask

    exp_t m;
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (sb_q.size() > 0) begin
                m = sb_q.pop_front();
                popped++;
                check("seg_a", m.k, 32'(seg_a), 32'(m.seg_a));
                check("dig_a", m.k, 32'(dig_a), 32'(m.dig_a));
                check("frame_done_a", m.k, 32'(fd_a), 32'(m.fd_a));
                check("seg_b", m.k, 32'(seg_b), 32'(m.seg_b));
                check("dig_b", m.k, 32'(dig_b), 32'(m.dig_b));
                check("frame_done_b", m.k, 32'(fd_b), 32'(m.fd_b));
            end
        end
    end

    initial begin
        logic [6:0] one;
        logic [6:0] zero;
        one  = 7'b0000110;
        zero = 7'b0111111;

        step(1'b1, zero, zero);
        step(1'b1, zero, zero);
        repeat (40) step(1'b0, one, zero);

        // Change the ones pattern during the second cycle of a lit ones slot.
        while (((t + 1) % 12) != 3) step(1'b0, one, zero);
        repeat (30) step(1'b0, one, one);

        // Single-cycle reset in the middle of the tens slot.
        while (((t + 1) % 12) != 9) step(1'b0, one, zero);
        step(1'b1, one, zero);
        repeat (30) step(1'b0, one, zero);

        // 60-count stream, including the 59 -> 00 wrap.
        for (int v = 0; v < 63; v++) begin
            repeat (5) step(1'b0, enc((v % 60) / 10), enc((v % 60) % 10));
        end

        // Random patterns with occasional resets.
        repeat (400) step($urandom_range(0, 39) == 0, 7'($urandom), 7'($urandom));

        repeat (3) step(1'b0, zero, zero);
        @(negedge clock);
        #3;
        check("scoreboard_drained", k, 32'(sb_q.size()), 32'd0);
        check("popped_vs_pushed", k, 32'(popped), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
